// File: rtl/bcd_down_counter_pkg.sv
// Shared definitions for the BCD down-counter: digit constants, FSM state type
// and the digit clamp helper.
package bcd_pkg;

  localparam int          BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  typedef enum logic {IDLE, RUN} state_t;

  // Non-decimal nibbles (A-F) saturate to 9 so the counter only ever holds valid BCD.
  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_counter_digit.sv
// Single mod-10 down-counting BCD stage; cascaded through borrow_out/dec_in.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_digit,
  input  logic             dec_in,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its neighbours' pre-edge values; blocking here would race the borrow chain.
  always_ff @(posedge clk) begin
    if (rst)
      digit <= '0;
    else if (ld)
      digit <= ld_digit;
    else if (dec_in)
      digit <= (digit == '0) ? BCD_MAX : digit - 1'b1;
  end

  assign borrow_out = dec_in && (digit == '0);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down-counter / interval timer with IDLE/RUN control.
// Optional periodic mode: define BCD_DOWN_COUNTER_AUTO_RELOAD_EN.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  zero
);

  localparam int W = BCD_W * DIGITS;

  state_t         state;
  logic [W-1:0]   clamped;
  logic [W-1:0]   ld_src;
  logic [DIGITS:0] borrow;
  logic           dec_go;
  logic           terminal;
  logic           ld_all;
  logic           dec;

  for (genvar i = 0; i < DIGITS; i++) begin : g_clamp
    assign clamped[i*BCD_W +: BCD_W] = clamp_digit(load_val[i*BCD_W +: BCD_W]);
  end

  // load beats en, so a same-cycle load never also decrements.
  assign dec_go   = (state == RUN) && en && !load;
  assign terminal = dec_go && (count == W'(1));

`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [W-1:0] reload;

  assign ld_all = load || terminal;
  assign ld_src = load ? clamped : reload;
  assign dec    = dec_go && !terminal && !zero;
`else
  assign ld_all = load;
  assign ld_src = clamped;
  assign dec    = dec_go && !zero;
`endif

  assign borrow[0] = dec;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .ld         (ld_all),
      .ld_digit   (ld_src[i*BCD_W +: BCD_W]),
      .dec_in     (borrow[i]),
      .digit      (count[i*BCD_W +: BCD_W]),
      .borrow_out (borrow[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done   <= 1'b0;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
      reload <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (load) begin
        state <= (clamped != '0) ? RUN : IDLE;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
        reload <= clamped;
`endif
      end else if (terminal) begin
        done <= 1'b1;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
        state <= RUN;
`else
        state <= IDLE;
`endif
      end else if (borrow[DIGITS]) begin
        // A borrow out of the top digit would mean counting past zero; park instead.
        state <= IDLE;
      end
    end
  end

  assign busy = (state == RUN);
  assign zero = (count == '0);

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed scoreboard bench for bcd_down_counter; the expected-value model
// follows BCD_DOWN_COUNTER_AUTO_RELOAD_EN the same way the design does.
module tb_bcd_down_counter;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         en = 1'b0;
  logic [W-1:0] count;
  logic         busy, done, zero;

  bcd_down_counter #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model holds the count as a plain decimal integer.
  int   m_cnt    = 0;
  int   m_reload = 0;
  logic m_run    = 1'b0;

  function automatic int bcd_to_int(input logic [W-1:0] v);
    int acc = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      int d = int'(v[i*4 +: 4]);
      if (d > 9) d = 9;
      acc = acc * 10 + d;
    end
    return acc;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int n);
    logic [W-1:0] r = '0;
    int t = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model(input logic r, input logic l, input logic [W-1:0] v,
                       input logic e);
    exp_t x;
    logic d = 1'b0;
    if (r) begin
      m_cnt = 0; m_run = 1'b0; m_reload = 0;
    end else if (l) begin
      m_cnt = bcd_to_int(v); m_reload = m_cnt; m_run = (m_cnt != 0);
    end else if (m_run && e) begin
      if (m_cnt == 1) begin
        d = 1'b1;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
        m_cnt = m_reload;
`else
        m_cnt = 0; m_run = 1'b0;
`endif
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
    x.count = int_to_bcd(m_cnt);
    x.busy  = m_run;
    x.done  = d;
    x.zero  = (m_cnt == 0);
    sb.push_back(x);
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, predict its result, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic l,
                      input logic [W-1:0] v, input logic e);
    exp_t x;
    @(negedge clk);
    rst = r; load = l; load_val = v; en = e;
    model(r, l, v, e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      x = sb.pop_front();
      check({tag, ".count"}, count, x.count);
      check({tag, ".busy"},  W'(busy), W'(x.busy));
      check({tag, ".done"},  W'(done), W'(x.done));
      check({tag, ".zero"},  W'(zero), W'(x.zero));
    end
  endtask

  initial begin
    // Reset overrides a simultaneous load.
    step("rst0", 1'b1, 1'b1, 8'h42, 1'b0);
    step("rst1", 1'b1, 1'b1, 8'h42, 1'b0);
    step("idle_en", 1'b0, 1'b0, 8'h00, 1'b1);

    // Basic run to terminal count.
    step("ld03", 1'b0, 1'b1, 8'h03, 1'b0);
    for (int i = 0; i < 4; i++) step("run03", 1'b0, 1'b0, 8'h00, 1'b1);

    // Borrow, clamp and zero load.
    step("ld10",   1'b0, 1'b1, 8'h10, 1'b0);
    step("borrow", 1'b0, 1'b0, 8'h00, 1'b1);
    step("ld1F",   1'b0, 1'b1, 8'h1F, 1'b0);
    step("ldFF",   1'b0, 1'b1, 8'hFF, 1'b0);
    step("ld00",   1'b0, 1'b1, 8'h00, 1'b0);
    step("idle00", 1'b0, 1'b0, 8'h00, 1'b1);

    // Enable gating and load priority.
    step("ld05",  1'b0, 1'b1, 8'h05, 1'b0);
    step("en1a",  1'b0, 1'b0, 8'h00, 1'b1);
    step("en0",   1'b0, 1'b0, 8'h00, 1'b0);
    step("en1b",  1'b0, 1'b0, 8'h00, 1'b1);
    step("ld20e", 1'b0, 1'b1, 8'h20, 1'b1);
    step("dec20", 1'b0, 1'b0, 8'h00, 1'b1);

    // Reset mid-run.
    step("ld50", 1'b0, 1'b1, 8'h50, 1'b0);
    for (int i = 0; i < 3; i++) step("run50", 1'b0, 1'b0, 8'h00, 1'b1);
    step("rst_mid",  1'b1, 1'b0, 8'h00, 1'b1);
    step("post_rst", 1'b0, 1'b0, 8'h00, 1'b1);

    // Periodic mode (or a plain run to zero when auto-reload is off).
    step("ld02", 1'b0, 1'b1, 8'h02, 1'b0);
    for (int i = 0; i < 6; i++) step("auto", 1'b0, 1'b0, 8'h00, 1'b1);

    // Load during run restarts the count; reset clears reload state.
    step("ld12",  1'b0, 1'b1, 8'h12, 1'b0);
    step("dec12", 1'b0, 1'b0, 8'h00, 1'b1);
    step("rst_e", 1'b1, 1'b0, 8'h00, 1'b0);
    step("ld01",  1'b0, 1'b1, 8'h01, 1'b0);
    step("tc01",  1'b0, 1'b0, 8'h00, 1'b1);
    step("tc01b", 1'b0, 1'b0, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard stop so the bench cannot run away if stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
